wb_heartbeat_ctrl: RTL and testbench
====================================

Name: wb_heartbeat_ctrl

Overview:
Wishbone-slave-controlled heartbeat generator for the Caravel user area.
- Sits between the Caravel management Wishbone bus (WB MI A) and a user GPIO pad.
- A programmable prescaler drives an 8-bit heartbeat counter.
- The counter MSB drives the pad.
- Firmware can enable, clear, pace and read back the counter, and can read and clear a sticky wrap flag.

Parameters:
- DIV_W, 16: prescaler reload width in bits.
- CNT_W, 8: heartbeat counter width in bits; out = count[CNT_W-1].
- BASE_ADDR, 32'h3000_0000: Wishbone base address; decode uses adr[31:4] == BASE_ADDR[31:4].

Ports:
- clk  input  1  single clock for all logic (wb_clk_i at the wrapper).
- nreset  input  1  asynchronous active-low reset.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_we_i  input  1  write enable.
- wbs_sel_i  input  4  byte selects.
- wbs_dat_i  input  32  write data.
- wbs_adr_i  input  32  byte address.
- wbs_ack_o  output  1  acknowledge.
- wbs_dat_o  output  32  read data.
- out  output  1  heartbeat output to the pad (count MSB).
- irq  output  1  level interrupt, = wrap_flag & irq_en.

Behaviour:
Reset (asynchronous assert, synchronous release edge):
- ctrl = 0, div = 0, count = 0, prescaler = 0, wrap_flag = 0.
- wbs_ack_o = 0, wbs_dat_o = 0, out = 0, irq = 0.

Register map (offset adr[3:2]); unmapped bits read 0:
- 0x0 CTRL (RW): bit0 enable, bit1 irq_en, bit2 clear. clear is self-clearing and always reads 0.
- 0x4 DIV (RW): [DIV_W-1:0] reload value.
- 0x8 COUNT (RO): [CNT_W-1:0] count. Writes are ignored but acked.
- 0xC STATUS: bit0 wrap_flag. Write 1 clears it (W1C); writing 0 has no effect.

Wishbone protocol (classic, one wait state):
- Request = stb & cyc & address hit & !wbs_ack_o.
- wbs_ack_o rises the cycle after the request and is a single-cycle pulse. Back-to-back requests are therefore acked every 2 cycles.
- Write data is committed on the ack cycle, honouring wbs_sel_i per byte lane.
- wbs_dat_o is valid on the ack cycle and 0 otherwise.
- Requests that miss the address decode are never acked.

Prescaler / counter:
- While enable = 1, prescaler counts down each cycle. When prescaler == 0, it reloads from div and count increments.
- Effective count period is div+1 cycles; div = 0 gives one increment per cycle.
- When enable = 0, prescaler and count hold their values.
- Count wraps from 2^CNT_W-1 to 0. On the wrap increment, wrap_flag is set.
- out is count[CNT_W-1], registered through count, so there is no extra latency.

Write effects:
- Writing CTRL with clear = 1 zeroes count and prescaler in the commit cycle.
- A clear takes priority over a simultaneous increment.
- A DIV write takes effect at the next reload; the current period is not truncated.
- Wrap set and a STATUS W1C in the same cycle: the set wins and wrap_flag stays 1.

Read timing:
- A read of COUNT returns the value registered in the request cycle.

Reset mid-transaction:
- Reset aborts the transaction immediately. No ack is issued, and no register is written.

Test Plan:
1. Reset, then read all four registers -> each acked exactly 1 cycle after the request; data 0,0,0,0; out = 0; irq = 0.
2. Write DIV = 3, then CTRL = 0x1 -> count increments every 4 cycles; after 512 cycles count = 0x80 and out = 1; after 1024 cycles count = 0x00 and wrap_flag = 1.
3. With CTRL = 0x3 and a wrap pending -> irq = 1. Write STATUS = 0x1 -> irq = 0 the cycle after the ack. Writing STATUS = 0x0 leaves the flag untouched.
4. Write DIV = 0, enable, then run 300 cycles -> count = 300 mod 256 = 44; one wrap is flagged. Write CTRL = 0x5 -> count = 0 and enable remains 1; a subsequent CTRL read returns 0x1.
5. Byte-lane write: DIV = 0xFFFF, then write 0x0000_1200 with sel = 4'b0010 -> DIV reads 0x12FF. Access at BASE_ADDR+0x10 -> no ack for 8 cycles.
6. Assert nreset during the wait state of a CTRL write of 0x1 -> no ack; after release CTRL reads 0 and the counter stays idle.

Source files
------------

// File: rtl/wb_heartbeat_ctrl.sv
// Wishbone-controlled heartbeat: a reloadable prescaler paces an 8-bit counter whose MSB drives a pad.
// Firmware can enable, clear, pace and read the counter, and owns a sticky wrap flag with optional IRQ.
module wb_heartbeat_ctrl #(
  parameter int          DIV_W     = 16,
  parameter int          CNT_W     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        out,
  output logic        irq
);

  typedef enum logic {S_IDLE, S_ACK} bus_state_t;

  bus_state_t state_reg, state_next;

  logic             we_reg;
  logic [1:0]       off_reg;
  logic [3:0]       sel_reg;
  logic [31:0]      wdat_reg;
  logic [31:0]      rdat_reg;
  logic [31:0]      rdata;
  logic             enable_reg, enable_next;
  logic             irq_en_reg, irq_en_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [DIV_W-1:0] presc_reg, presc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             wrap_reg, wrap_next;
  logic             hit, req, commit;
  logic             wr_ctrl, wr_div, wr_status, clear, wrap_set;
  logic             unused_bits;

  assign hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // The ACK state blocks a new request, so back-to-back accesses are served every other cycle.
  assign req = wbs_stb_i & wbs_cyc_i & hit & (state_reg == S_IDLE);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (req) state_next = S_ACK;
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign wbs_ack_o = (state_reg == S_ACK);
  assign wbs_dat_o = rdat_reg;

  // Writes land on the edge that closes the ack cycle, using fields captured at the request.
  assign commit    = (state_reg == S_ACK) & we_reg;
  assign wr_ctrl   = commit & (off_reg == 2'd0);
  assign wr_div    = commit & (off_reg == 2'd1);
  assign wr_status = commit & (off_reg == 2'd3);
  assign clear     = wr_ctrl & sel_reg[0] & wdat_reg[2];

  always_comb begin
    enable_next = enable_reg;
    irq_en_next = irq_en_reg;
    if (wr_ctrl && sel_reg[0]) begin
      enable_next = wdat_reg[0];
      irq_en_next = wdat_reg[1];
    end
  end

  generate
    for (genvar gi = 0; gi < DIV_W; gi++) begin : g_div_bit
      assign div_next[gi] = (wr_div && sel_reg[gi/8]) ? wdat_reg[gi] : div_reg[gi];
    end
  endgenerate

  // Clear beats a same-cycle increment, so a clear can never raise the wrap flag.
  always_comb begin
    presc_next = presc_reg;
    count_next = count_reg;
    wrap_set   = 1'b0;
    if (clear) begin
      presc_next = '0;
      count_next = '0;
    end else if (enable_reg) begin
      if (presc_reg == '0) begin
        presc_next = div_reg;
        count_next = count_reg + CNT_W'(1);
        wrap_set   = &count_reg;
      end else begin
        presc_next = presc_reg - DIV_W'(1);
      end
    end
  end

  assign wrap_next = wrap_set | (wrap_reg & ~(wr_status & sel_reg[0] & wdat_reg[0]));

  always_comb begin
    rdata = '0;
    case (wbs_adr_i[3:2])
      2'd0:    rdata[1:0]       = {irq_en_reg, enable_reg};
      2'd1:    rdata[DIV_W-1:0] = div_reg;
      2'd2:    rdata[CNT_W-1:0] = count_reg;
      default: rdata[0]         = wrap_reg;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      we_reg     <= 1'b0;
      off_reg    <= '0;
      sel_reg    <= '0;
      wdat_reg   <= '0;
      rdat_reg   <= '0;
      enable_reg <= 1'b0;
      irq_en_reg <= 1'b0;
      div_reg    <= '0;
      presc_reg  <= '0;
      count_reg  <= '0;
      wrap_reg   <= 1'b0;
    end else begin
      rdat_reg   <= req ? rdata : '0;
      if (req) begin
        we_reg   <= wbs_we_i;
        off_reg  <= wbs_adr_i[3:2];
        sel_reg  <= wbs_sel_i;
        wdat_reg <= wbs_dat_i;
      end
      enable_reg <= enable_next;
      irq_en_reg <= irq_en_next;
      div_reg    <= div_next;
      presc_reg  <= presc_next;
      count_reg  <= count_next;
      wrap_reg   <= wrap_next;
    end
  end

  assign out = count_reg[CNT_W-1];
  assign irq = wrap_reg & irq_en_reg;

  assign unused_bits = ^{wbs_adr_i[1:0], wdat_reg, sel_reg};

endmodule

// File: tb/tb_wb_heartbeat_ctrl.sv
// Directed bench for wb_heartbeat_ctrl: register-access vector table plus timed counter/IRQ/reset sequences.
module tb_wb_heartbeat_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        nreset;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i, wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        out, irq;

  wb_heartbeat_ctrl #(.DIV_W(16), .CNT_W(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .nreset(nreset),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .out(out), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_mis = 0;
  logic irq_at_ack;

  typedef struct {
    logic        we;
    logic [3:0]  off;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that commits the access.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int max_wait,
                         output logic [31:0] rdata, output int lat);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    lat = -1; rdata = '0; irq_at_ack = 1'b0;
    for (int i = 1; i <= max_wait; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin
        lat = i; rdata = wbs_dat_o; irq_at_ack = irq;
        break;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    if (lat >= 0) begin
      @(posedge clk); #1;
    end
    $display("wb %s adr=%h wdat=%h sel=%b rdat=%h lat=%0d", we ? "wr" : "rd", adr, dat, sel, rdata, lat);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] r; int l;
    wb_xfer(1'b0, BASE + 32'(off), 32'h0, 4'hF, 8, r, l);
    chk({name, "_lat"}, 32'(l), 32'd1);
    chk(name, r, exp);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] r; int l;
    wb_xfer(1'b1, BASE + 32'(off), dat, sel, 8, r, l);
    chk("wr_lat", 32'(l), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    int          l;
    logic [3:0]  pat;

    //            we    off   dat           sel     exp
    vecs[0]  = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h0};
    vecs[1]  = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h0};
    vecs[2]  = '{1'b0, 4'h8, 32'h0,        4'hF, 32'h0};
    vecs[3]  = '{1'b0, 4'hC, 32'h0,        4'hF, 32'h0};
    vecs[4]  = '{1'b1, 4'h4, 32'h0000FFFF, 4'hF, 32'h0};
    vecs[5]  = '{1'b1, 4'h4, 32'h00001200, 4'h2, 32'h0};
    vecs[6]  = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h000012FF};
    vecs[7]  = '{1'b1, 4'h4, 32'hABCD5678, 4'hF, 32'h0};
    vecs[8]  = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h00005678};
    vecs[9]  = '{1'b1, 4'h4, 32'hFFFFFFFF, 4'h0, 32'h0};
    vecs[10] = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h00005678};
    vecs[11] = '{1'b1, 4'h0, 32'h00000002, 4'hF, 32'h0};
    vecs[12] = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h00000002};
    vecs[13] = '{1'b1, 4'h0, 32'hFFFFFFF8, 4'hF, 32'h0};
    vecs[14] = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h0};
    vecs[15] = '{1'b1, 4'h8, 32'h000000FF, 4'hF, 32'h0};
    vecs[16] = '{1'b0, 4'h8, 32'h0,        4'hF, 32'h0};
    vecs[17] = '{1'b1, 4'hC, 32'h00000001, 4'hF, 32'h0};
    vecs[18] = '{1'b0, 4'hC, 32'h0,        4'hF, 32'h0};
    vecs[19] = '{1'b1, 4'h4, 32'h00000003, 4'hF, 32'h0};

    nreset = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_dat_i = '0; wbs_adr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 32'(wbs_ack_o), 32'd0);
    chk("reset_dat", wbs_dat_o, 32'h0);
    nreset = 1'b1;
    @(posedge clk); #1;
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);

    // Register access with the counter disabled; last entry leaves DIV = 3.
    for (int i = 0; i < 20; i++) begin
      wb_xfer(vecs[i].we, BASE + 32'(vecs[i].off), vecs[i].dat, vecs[i].sel, 8, r, l);
      chk($sformatf("vec%0d_lat", i), 32'(l), 32'd1);
      if (!vecs[i].we) chk($sformatf("vec%0d_dat", i), r, vecs[i].exp);
    end

    // Held strobe: acks arrive every other cycle.
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE + 32'h4;
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat = {pat[2:0], wbs_ack_o};
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(posedge clk); #1;
    chk("b2b_ack_pattern", 32'(pat), 32'h0000000A);

    // Address miss is never acked.
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 8, r, l);
    chk("miss_no_ack", 32'(l), 32'hFFFFFFFF);

    // DIV = 3: one increment per 4 enabled cycles.
    wr(4'h0, 32'h1, 4'hF);
    repeat (512) @(posedge clk);
    #1;
    chk("out_at_512", 32'(out), 32'd1);
    rd_chk("count_512", 4'h8, 32'h80);
    repeat (510) @(posedge clk);
    #1;
    chk("out_at_1024", 32'(out), 32'd0);
    rd_chk("count_1024", 4'h8, 32'h00);
    rd_chk("wrap_flag_1024", 4'hC, 32'h1);

    // Interrupt enable, W0 no-op, W1C.
    wr(4'h0, 32'h3, 4'hF);
    chk("irq_pending", 32'(irq), 32'd1);
    wr(4'hC, 32'h0, 4'hF);
    chk("irq_after_w0", 32'(irq), 32'd1);
    rd_chk("status_after_w0", 4'hC, 32'h1);
    wr(4'hC, 32'h1, 4'hF);
    chk("irq_on_w1c_ack", 32'(irq_at_ack), 32'd1);
    chk("irq_after_w1c", 32'(irq), 32'd0);
    rd_chk("status_after_w1c", 4'hC, 32'h0);

    // DIV = 0 from a cleared, stopped counter: one increment per cycle.
    wr(4'h0, 32'h4, 4'hF);
    wr(4'hC, 32'h1, 4'hF);
    wr(4'h4, 32'h0, 4'hF);
    wr(4'h0, 32'h1, 4'hF);
    repeat (300) @(posedge clk);
    #1;
    rd_chk("count_300", 4'h8, 32'd44);
    rd_chk("wrap_after_300", 4'hC, 32'h1);
    wr(4'h0, 32'h5, 4'hF);
    rd_chk("count_after_clear", 4'h8, 32'h0);
    rd_chk("ctrl_after_clear", 4'h0, 32'h1);

    // Reset during the wait state of a CTRL write.
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = BASE; wbs_dat_i = 32'h1; wbs_sel_i = 4'hF;
    #2 nreset = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_no_ack", 32'(wbs_ack_o), 32'd0);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_held_no_ack", 32'(wbs_ack_o), 32'd0);
    nreset = 1'b1;
    @(posedge clk); #1;
    rd_chk("ctrl_after_rst", 4'h0, 32'h0);
    rd_chk("div_after_rst", 4'h4, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    rd_chk("count_idle_after_rst", 4'h8, 32'h0);
    chk("out_after_rst", 32'(out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
